mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, 16-byte-aligned base of the register window.
REQ-002 Parameter CLK_DIV, default 434, clock cycles per serial bit (range 2..65535).
REQ-003 Parameter FIFO_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 bus_addr  input  32  byte address from CPU data port.
REQ-007 bus_wmask  input  4  byte write mask.
REQ-008 bus_wdata  input  32  write data.
REQ-009 bus_w_en  input  1  write strobe, one cycle per store.
REQ-010 bus_rdata  output  32  registered read data.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-013 Hit = bus_addr[31:4] == BASE_ADDR[31:4]; offset = bus_addr[3:2].
REQ-014 Offset 0 TXDATA: bus_w_en & hit & bus_wmask[0] pushes bus_wdata[7:0]; reads return 0.
REQ-015 Offset 1 STATUS (read): bit0 tx_busy, bit1 fifo_full, bit2 fifo_empty, bit3 overflow, bits[8:4] fifo count, others 0.
REQ-016 Write to STATUS with bus_wmask[0] & bus_wdata[3] clears overflow; other bits are read-only.
REQ-017 Offsets 2, 3 and non-hit addresses: read 0, writes ignored.
REQ-018 bus_rdata is updated every cycle from the current bus_addr; read latency is exactly 1 cycle.
REQ-019 Push while full: byte dropped, overflow set (sticky), FIFO unchanged.
REQ-020 Push and pop in the same cycle while full: both occur, no overflow, count unchanged.
REQ-021 Push while empty: byte visible to the serializer on the next cycle, never in the same cycle.
REQ-022 Serializer FSM states are IDLE, START, DATA, PARITY (macro only), STOP.
REQ-023 IDLE: tx=1; if FIFO non-empty, pop into shift register and enter START next cycle.
REQ-024 START: tx=0 for CLK_DIV cycles, then DATA.
REQ-025 DATA: 8 bits LSB first, each CLK_DIV cycles, 3-bit bit counter; after bit 7 enter PARITY or STOP.
REQ-026 STOP: tx=1 for CLK_DIV cycles, then IDLE.
REQ-027 Back-to-back frames are separated by exactly 1 IDLE cycle; frame period is 10*CLK_DIV+1 cycles (11*CLK_DIV+1 with parity).
REQ-028 Baud counter is 16 bits, counts 0..CLK_DIV-1, and restarts at 0 on every state entry.

Reset
REQ-029 On reset: FSM=IDLE, tx=1, tx_busy=0, FIFO empty, overflow=0, bus_rdata=0, counters=0.
REQ-030 Reset mid-frame aborts the frame, drives tx=1 at the next edge, and discards the FIFO contents.

Configuration
REQ-031 With UART_TX_PARITY_EN defined: PARITY state follows DATA, drives the even parity of the byte for CLK_DIV cycles, and STATUS bit9 reads 1.
REQ-032 Without UART_TX_PARITY_EN: no PARITY state exists, DATA goes directly to STOP, and STATUS bit9 reads 0.

Structure
REQ-033 The shared defines file holds register offsets, STATUS bit positions and FSM state encodings.
REQ-034 The FIFO is a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count).
REQ-035 The serializer FSM and the bus decode stay in mmio_uart_tx.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-036 Write 0x55 to BASE+0 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4; tx_busy falls after stop.
REQ-037 Read BASE+4 after reset -> bus_rdata=32'h0000_0004 one cycle later.
REQ-038 Six back-to-back writes 0x01..0x06 -> 0x01 sent at once, 0x02..0x05 buffered, 0x06 dropped, overflow=1; wire shows 5 frames 41 cycles apart.
REQ-039 With overflow set, write 32'h8 to BASE+4 -> STATUS bit3 reads 0.
REQ-040 Reset asserted in DATA bit 3 -> tx=1 next cycle, STATUS=32'h4, no further frames.
REQ-041 UART_TX_PARITY_EN defined, write 0x07 -> parity bit=1, frame 44 cycles; write 0x03 -> parity bit=0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - register map, STATUS bit positions and serializer states
// UART_TX_PARITY_EN adds the PARITY state.
package mmio_uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  localparam int ST_BUSY_BIT   = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_EMPTY_BIT  = 2;
  localparam int ST_OVF_BIT    = 3;
  localparam int ST_COUNT_LSB  = 4;
  localparam int ST_PARITY_BIT = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU data-port bus as seen by the UART register window
interface mmio_uart_tx_if;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_wdata;
  logic        bus_w_en;
  logic [31:0] bus_rdata;

  modport master (output bus_addr, bus_wmask, bus_wdata, bus_w_en, input bus_rdata);
  modport slave  (input bus_addr, bus_wmask, bus_wdata, bus_w_en, output bus_rdata);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - synchronous FIFO; a push while full is dropped unless a pop frees a slot
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == FULL_COUNT;
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           tx_busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  logic          hit;
  logic [1:0]    offset;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [7:0]    fifo_dout;
  logic          overflow;
  logic [31:0]   status;
  logic [31:0]   rdata;
  tx_state_t     state;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          baud_done;
  logic          unused_bits;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign hit       = bus.bus_addr[31:4] == BASE_ADDR[31:4];
  assign offset    = bus.bus_addr[3:2];
  assign push_req  = bus.bus_w_en & hit & (offset == OFF_TXDATA) & bus.bus_wmask[0];
  assign pop       = (state == S_IDLE) & ~empty;
  assign baud_done = baud_cnt == BAUD_LAST;
  assign tx_busy   = (state != S_IDLE) | ~empty;
  assign bus.bus_rdata = rdata;
  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wmask[3:1], bus.bus_wdata[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (bus.bus_wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status = '0;
    status[ST_BUSY_BIT]            = tx_busy;
    status[ST_FULL_BIT]            = full;
    status[ST_EMPTY_BIT]           = empty;
    status[ST_OVF_BIT]             = overflow;
    status[ST_COUNT_LSB +: CW]     = count;
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY_BIT]          = 1'b1;
`endif
  end

  // A push that lands on a full FIFO is only lost when the serializer is not popping that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      overflow <= 1'b0;
    end else begin
      rdata <= (hit && offset == OFF_STATUS) ? status : '0;
      if (push_req & full & ~pop)
        overflow <= 1'b1;
      else if (bus.bus_w_en & hit & (offset == OFF_STATUS) & bus.bus_wmask[0] & bus.bus_wdata[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!empty) begin
            shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(fifo_dout);
`endif
            state <= S_START;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity_bit;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              shift <= shift >> 1;
              tx    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed bench for mmio_uart_tx at CLK_DIV=4, FIFO_DEPTH=4
// Define UART_TX_PARITY_EN to also exercise the parity frame.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSEG = 11;
  localparam logic [31:0] PBIT = 32'h200;
`else
  localparam int NSEG = 10;
  localparam logic [31:0] PBIT = 32'h0;
`endif
  localparam int FRAME = NSEG * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic tx_busy;
  int   n_checks = 0;
  int   n_errors = 0;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Line decoder: records each completed frame (start cycle, data byte, stop level).
  int         cyc = 0;
  int         mon_pos = -1;
  int         mon_start = 0;
  logic [7:0] mon_byte = 8'h00;
  int         q_start [$];
  logic [7:0] q_byte  [$];
  logic       q_stop  [$];

  always @(negedge clk) begin
    cyc++;
    if (reset === 1'b1) begin
      mon_pos = -1;
    end else if (mon_pos < 0) begin
      if (tx === 1'b0) begin
        mon_pos   = 1;
        mon_start = cyc;
      end
    end else begin
      if (mon_pos % DIV == 2) begin
        if (mon_pos / DIV >= 1 && mon_pos / DIV <= 8) begin
          mon_byte[mon_pos / DIV - 1] = tx;
        end else if (mon_pos / DIV == NSEG - 1) begin
          q_start.push_back(mon_start);
          q_byte.push_back(mon_byte);
          q_stop.push_back(tx);
          mon_pos = -2;
        end
      end
      mon_pos++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    @(negedge clk);
    bus.bus_addr  = addr;
    bus.bus_wmask = mask;
    bus.bus_wdata = data;
    bus.bus_w_en  = 1'b1;
    @(negedge clk);
    bus.bus_w_en  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.bus_addr = addr;
    bus.bus_w_en = 1'b0;
    @(negedge clk);
    check(tag, 64'(bus.bus_rdata), 64'(exp));
  endtask

  function automatic logic [63:0] exp_frame(input logic [7:0] b);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < FRAME; i++) begin
      int s;
      s = i / DIV;
      if (s == 0)             v[i] = 1'b0;
      else if (s <= 8)        v[i] = b[s-1];
      else if (s == NSEG - 1) v[i] = 1'b1;
      else                    v[i] = ^b;
    end
    return v;
  endfunction

  task automatic capture(input string tag, output logic [63:0] cap);
    int guard;
    guard = 0;
    cap = '0;
    while (tx !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_start_seen"}, 64'(guard < 200), 64'(1));
    for (int i = 0; i < FRAME; i++) begin
      cap[i] = tx;
      @(negedge clk);
    end
  endtask

  task automatic clear_mon();
    q_start.delete();
    q_byte.delete();
    q_stop.delete();
  endtask

  logic [7:0]  fill_bytes [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
  logic [63:0] cap;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    bus.bus_addr  = '0;
    bus.bus_wmask = '0;
    bus.bus_wdata = '0;
    bus.bus_w_en  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_tx", 64'(tx), 64'(1));
    check("reset_busy", 64'(tx_busy), 64'(0));
    check("reset_rdata", 64'(bus.bus_rdata), 64'(0));
    rd_check("status_after_reset", BASE + 32'h4, 32'h4 | PBIT);
    rd_check("txdata_reads_zero", BASE, 32'h0);
    rd_check("offset2_reads_zero", BASE + 32'h8, 32'h0);
    rd_check("nonhit_reads_zero", BASE + 32'h14, 32'h0);

    wr(BASE, 4'b1110, 32'h99);
    wr(BASE + 32'h8, 4'hF, 32'h77);
    wr(BASE + 32'h10, 4'hF, 32'h66);
    rd_check("ignored_writes", BASE + 32'h4, 32'h4 | PBIT);

    clear_mon();
    wr(BASE, 4'h1, 32'h55);
    check("busy_after_push", 64'(tx_busy), 64'(1));
    capture("frame_55", cap);
    check("frame_55_wave", cap, exp_frame(8'h55));
    check("busy_after_stop", 64'(tx_busy), 64'(0));
    check("idle_high", 64'(tx), 64'(1));

    clear_mon();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.bus_addr  = BASE;
      bus.bus_wmask = 4'h1;
      bus.bus_wdata = 32'(k);
      bus.bus_w_en  = 1'b1;
    end
    rd_check("status_burst", BASE + 32'h4, 32'h4B | PBIT);
    repeat (5 * (FRAME + 1) + 20) @(negedge clk);
    check("burst_frame_count", 64'(q_byte.size()), 64'(5));
    for (int i = 0; i < q_byte.size(); i++) begin
      check("burst_byte", 64'(q_byte[i]), 64'(i + 1));
      check("burst_stop", 64'(q_stop[i]), 64'(1));
    end
    for (int i = 1; i < q_start.size(); i++)
      check("burst_gap", 64'(q_start[i] - q_start[i-1]), 64'(FRAME + 1));
    rd_check("overflow_sticky", BASE + 32'h4, 32'hC | PBIT);
    wr(BASE + 32'h4, 4'h1, 32'h0);
    rd_check("overflow_kept_bit3_zero", BASE + 32'h4, 32'hC | PBIT);
    wr(BASE + 32'h4, 4'b1110, 32'h8);
    rd_check("overflow_kept_mask0_zero", BASE + 32'h4, 32'hC | PBIT);
    wr(BASE + 32'h4, 4'h1, 32'h8);
    rd_check("overflow_cleared", BASE + 32'h4, 32'h4 | PBIT);

    // Fill the FIFO, then push exactly on the cycle the serializer pops.
    clear_mon();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.bus_addr  = BASE;
      bus.bus_wmask = 4'h1;
      bus.bus_wdata = 32'(fill_bytes[k]);
      bus.bus_w_en  = 1'b1;
    end
    @(negedge clk);
    bus.bus_w_en = 1'b0;
    repeat (FRAME - 3) @(negedge clk);
    bus.bus_wdata = 32'(fill_bytes[5]);
    bus.bus_w_en  = 1'b1;
    @(negedge clk);
    bus.bus_w_en  = 1'b0;
    rd_check("push_pop_full", BASE + 32'h4, 32'h43 | PBIT);
    repeat (6 * (FRAME + 1) + 20) @(negedge clk);
    check("pushpop_frame_count", 64'(q_byte.size()), 64'(6));
    for (int i = 0; i < q_byte.size() && i < 6; i++)
      check("pushpop_byte", 64'(q_byte[i]), 64'(fill_bytes[i]));

    clear_mon();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.bus_addr  = BASE;
      bus.bus_wmask = 4'h1;
      bus.bus_wdata = (k == 0) ? 32'h52 : (k == 1) ? 32'h11 : 32'h22;
      bus.bus_w_en  = 1'b1;
    end
    @(negedge clk);
    bus.bus_w_en = 1'b0;
    repeat (15) @(negedge clk);
    check("data_bit3_low", 64'(tx), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_tx", 64'(tx), 64'(1));
    check("reset_mid_busy", 64'(tx_busy), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    rd_check("status_after_abort", BASE + 32'h4, 32'h4 | PBIT);
    repeat (3 * FRAME) @(negedge clk);
    check("no_frames_after_abort", 64'(q_byte.size()), 64'(0));
    check("line_idle_after_abort", 64'(tx), 64'(1));

`ifdef UART_TX_PARITY_EN
    wr(BASE, 4'h1, 32'h07);
    capture("frame_07", cap);
    check("frame_07_wave", cap, exp_frame(8'h07));
    check("parity_07", 64'(cap[9*DIV+1]), 64'(1));
    wr(BASE, 4'h1, 32'h03);
    capture("frame_03", cap);
    check("parity_03", 64'(cap[9*DIV+1]), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
